// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS core.
// Drives every datapath enable and mux select from the current state. The
// FETCH state's ir_write and pc_write also depend on mem_ready. Memory states
// wait on the mem_ready handshake. A bounded wait counter sends the FSM to TRAP
// when memory stalls too long. Illegal opcodes also end in TRAP. TRAP holds
// until reset.
//
// Optional feature: define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt
// performance counters and their ports.
//
// Parameters:
//   WAIT_LIMIT  max consecutive mem_ready-low cycles in one memory state
//   WAIT_W      wait-counter width (WAIT_LIMIT <= 2**WAIT_W-1)
//   CNT_W       perf-counter width (MC_PERF_CNT_EN only)
// Ports:
//   clk, reset (async, active-low), opcode (IR[31:26]), zero (datapath use),
//   mem_ready (memory completes access this cycle)
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
//   reg_write, reg_dst, alu_src_a, pc_source, alu_op, alu_src_b: datapath controls
//   state (debug, 4 bits), trap (high in TRAP)
//   cycle_cnt, instr_cnt (MC_PERF_CNT_EN only)
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WAIT_W     = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       state,
  output logic             trap
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];

  state_t            cur_state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              wait_state;
  logic              timeout;

  // The branch decision itself is made in the datapath from pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    wait_state = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
    // mem_ready on the limit cycle takes priority over the timeout.
    timeout    = wait_state && !mem_ready && (wait_cnt == LIMIT);
    // The counter is zero outside the wait states, so every wait state is
    // entered with a cleared counter.
    wait_next  = (wait_state && !mem_ready && !timeout) ? wait_cnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= wait_next;
    end
  end

  always_comb begin
    next_state    = cur_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;
    trap          = 1'b0;
    state         = cur_state;

    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    next_state = DECODE;
        else if (timeout) next_state = TRAP;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      next_state = MEMRD;
        else if (opcode == OP_SW) next_state = MEMWR;
        else                      next_state = TRAP;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    next_state = MEMWB;
        else if (timeout) next_state = TRAP;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)    next_state = FETCH;
        else if (timeout) next_state = TRAP;
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        pc_write_cond = 1'b1;
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        next_state    = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        next_state = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      default: begin
        trap       = 1'b1;
        next_state = TRAP;
      end
    endcase

    // While reset is held every output is quiet, including the FETCH strobes.
    if (!reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 2'b00;
      alu_src_b     = 2'b00;
      trap          = 1'b0;
      state         = '0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic final_state;
  assign final_state = (cur_state == MEMWB)  || (cur_state == MEMWR) ||
                       (cur_state == RTYPEWB) || (cur_state == ADDIWB) ||
                       (cur_state == BRANCH) || (cur_state == JUMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cur_state != TRAP) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (final_state && (next_state == FETCH)) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl. Instructions
// are expanded into per-cycle plans of expected state and mem_ready. The
// expected controls come from a table of the documented per-state outputs.
module tb_multicycle_ctrl;
  localparam int unsigned WAIT_LIMIT = 15;
  localparam int unsigned CNT_W      = 32;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_RTYPEWB = 7, S_BRANCH = 8, S_JUMP = 9,
                 S_ADDIEX = 10, S_ADDIWB = 11, S_TRAP = 12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write;
  logic reg_write, reg_dst, alu_src_a, trap;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .WAIT_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .pc_source(pc_source), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .state(state), .trap(trap)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                     ir_write, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
                     alu_src_b, trap};

  int tests_run = 0;
  int tests_failed = 0;
  longint exp_cyc = 0;
  longint exp_ins = 0;

  int         plan_st[$];
  bit         plan_rdy[$];
  bit         plan_fin[$];
  logic [5:0] plan_op[$];

  // Documented control outputs for each state.
  function automatic logic [16:0] exp_ctrl(int st, bit rdy);
    logic pw, pwc, iod, mr, mw, m2r, irw, rw, rd, asa, tr;
    logic [1:0] pcs, aop, asb;
    {pw, pwc, iod, mr, mw, m2r, irw, rw, rd, asa, tr} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      S_FETCH:            begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE:           asb = 2'b11;
      S_MEMADR, S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_MEMRD:            begin mr = 1; iod = 1; end
      S_MEMWB:            begin rw = 1; m2r = 1; end
      S_MEMWR:            begin mw = 1; iod = 1; end
      S_EXEC:             begin asa = 1; aop = 2'b10; end
      S_RTYPEWB:          begin rw = 1; rd = 1; end
      S_ADDIWB:           rw = 1;
      S_BRANCH:           begin pwc = 1; asa = 1; aop = 2'b01; pcs = 2'b01; end
      S_JUMP:             begin pw = 1; pcs = 2'b10; end
      default:            tr = 1;
    endcase
    return {pw, pwc, iod, mr, mw, m2r, irw, rw, rd, asa, pcs, aop, asb, tr};
  endfunction

  task automatic push(input int st, input bit rdy, input bit fin, input logic [5:0] op);
    plan_st.push_back(st); plan_rdy.push_back(rdy);
    plan_fin.push_back(fin); plan_op.push_back(op);
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one legal instruction: fw fetch waits, mw memory waits.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, 1'b0, op);
    push(S_FETCH, 1'b1, 1'b0, op);
    push(S_DECODE, rnd_bit(), 1'b0, op);
    case (op)
      OP_R:    begin push(S_EXEC, rnd_bit(), 0, op); push(S_RTYPEWB, rnd_bit(), 1, op); end
      OP_LW: begin
        push(S_MEMADR, rnd_bit(), 0, op);
        for (int i = 0; i < mw; i++) push(S_MEMRD, 1'b0, 1'b0, op);
        push(S_MEMRD, 1'b1, 1'b0, op);
        push(S_MEMWB, rnd_bit(), 1'b1, op);
      end
      OP_SW: begin
        push(S_MEMADR, rnd_bit(), 0, op);
        for (int i = 0; i < mw; i++) push(S_MEMWR, 1'b0, 1'b0, op);
        push(S_MEMWR, 1'b1, 1'b1, op);
      end
      OP_BEQ:  push(S_BRANCH, rnd_bit(), 1, op);
      OP_J:    push(S_JUMP, rnd_bit(), 1, op);
      default: begin push(S_ADDIEX, rnd_bit(), 0, op); push(S_ADDIWB, rnd_bit(), 1, op); end
    endcase
  endtask

  // Entered and left just after a falling edge.
  task automatic exec_plan(input string tag);
    for (int i = 0; i < plan_st.size(); i++) begin
      mem_ready = plan_rdy[i];
      zero = rnd_bit();
      if (plan_st[i] == S_DECODE || plan_st[i] == S_MEMADR) opcode = plan_op[i];
      else opcode = 6'($urandom);
      #1;
      tests_run++;
      if (state !== 4'(plan_st[i])) begin
        tests_failed++;
        $display("FAIL %s state cyc %0d: got %0d want %0d", tag, i, state, plan_st[i]);
      end
      tests_run++;
      if (act_ctrl !== exp_ctrl(plan_st[i], plan_rdy[i])) begin
        tests_failed++;
        $display("FAIL %s ctrl cyc %0d: got %b want %b", tag, i, act_ctrl,
                 exp_ctrl(plan_st[i], plan_rdy[i]));
      end
`ifdef MC_PERF_CNT_EN
      tests_run++;
      if (cycle_cnt !== CNT_W'(exp_cyc) || instr_cnt !== CNT_W'(exp_ins)) begin
        tests_failed++;
        $display("FAIL %s perf cyc %0d: got %0d/%0d want %0d/%0d", tag, i,
                 cycle_cnt, instr_cnt, exp_cyc, exp_ins);
      end
`endif
      if (plan_st[i] != S_TRAP) exp_cyc++;
      if (plan_fin[i]) exp_ins++;
      @(negedge clk);
    end
    plan_st.delete(); plan_rdy.delete(); plan_fin.delete(); plan_op.delete();
  endtask

  // Asserts reset, checks the quiet outputs across a clock edge, then releases it.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    exp_cyc = 0;
    exp_ins = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if (state !== 4'd0 || act_ctrl !== 17'd0) begin
        tests_failed++;
        $display("FAIL %s reset outputs: got state %0d ctrl %b want 0 0", tag, state, act_ctrl);
      end
`ifdef MC_PERF_CNT_EN
      tests_run++;
      if (cycle_cnt !== '0 || instr_cnt !== '0) begin
        tests_failed++;
        $display("FAIL %s reset perf: got %0d/%0d want 0/0", tag, cycle_cnt, instr_cnt);
      end
`endif
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_rtype_ready_tied();
    for (int n = 0; n < 3; n++) add_instr(OP_R, 0, 0);
    exec_plan("rtype");
  endtask

  task automatic test_lw_waits();
    add_instr(OP_LW, 0, 3);
    exec_plan("lw_wait");
  endtask

  task automatic test_beq_jump();
    add_instr(OP_BEQ, 0, 0);
    add_instr(OP_J, 1, 0);
    add_instr(OP_ADDI, 0, 0);
    add_instr(OP_SW, 0, 0);
    exec_plan("beq_j");
  endtask

  task automatic test_wait_limit_boundary();
    add_instr(OP_LW, WAIT_LIMIT, WAIT_LIMIT);
    add_instr(OP_SW, 0, WAIT_LIMIT);
    exec_plan("limit_ok");
  endtask

  task automatic test_sw_timeout();
    push(S_FETCH, 1, 0, OP_SW);
    push(S_DECODE, rnd_bit(), 0, OP_SW);
    push(S_MEMADR, rnd_bit(), 0, OP_SW);
    for (int i = 0; i < WAIT_LIMIT + 1; i++) push(S_MEMWR, 0, 0, OP_SW);
    for (int i = 0; i < 3; i++) push(S_TRAP, rnd_bit(), 0, OP_SW);
    exec_plan("sw_timeout");
    do_reset("sw_timeout_rst");
    for (int i = 0; i < WAIT_LIMIT + 1; i++) push(S_FETCH, 0, 0, OP_R);
    for (int i = 0; i < 2; i++) push(S_TRAP, rnd_bit(), 0, OP_R);
    exec_plan("fetch_timeout");
    do_reset("fetch_timeout_rst");
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) op = 6'b111111;
      else begin
        do op = 6'($urandom);
        while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      push(S_FETCH, 1, 0, op);
      push(S_DECODE, rnd_bit(), 0, op);
      for (int i = 0; i < 4; i++) push(S_TRAP, rnd_bit(), 0, op);
      exec_plan("illegal");
      do_reset("illegal_rst");
      add_instr(OP_R, 0, 0);
      exec_plan("after_trap");
    end
  endtask

  task automatic test_reset_mid_access();
    push(S_FETCH, 1, 0, OP_LW);
    push(S_DECODE, rnd_bit(), 0, OP_LW);
    push(S_MEMADR, rnd_bit(), 0, OP_LW);
    push(S_MEMRD, 0, 0, OP_LW);
    push(S_MEMRD, 0, 0, OP_LW);
    exec_plan("mid_access");
    do_reset("mid_access_rst");
    add_instr(OP_LW, 0, WAIT_LIMIT);
    exec_plan("post_abort");
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    for (int n = 0; n < 60; n++) begin
      int fw, mw;
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, WAIT_LIMIT)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, WAIT_LIMIT)) : int'($urandom_range(0, 3));
      add_instr(ops[$urandom_range(0, 5)], fw, mw);
    end
    exec_plan("random");
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    do_reset("perf_rst");
    for (int n = 0; n < 10; n++) add_instr(OP_ADDI, 0, 0);
    exec_plan("perf_addi");
    #1;
    tests_run++;
    if (instr_cnt !== CNT_W'(10) || cycle_cnt !== CNT_W'(40)) begin
      tests_failed++;
      $display("FAIL perf_10addi: got instr %0d cycle %0d want 10 40", instr_cnt, cycle_cnt);
    end
    @(negedge clk);
    push(S_FETCH, 1, 0, OP_ADDI);
    push(S_DECODE, rnd_bit(), 0, OP_ADDI);
    exec_plan("perf_pre");
    do_reset("perf_mid_decode_rst");
  endtask
`endif

  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    opcode = '0;
    zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype_ready_tied();
    test_lw_waits();
    test_beq_jump();
    test_wait_limit_boundary();
    test_sw_timeout();
    test_illegal();
    test_reset_mid_access();
    test_random();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
